inst_fetch: RTL and testbench

Instruction-fetch stage between `pc_reg` and the ID stage of the pipeline. It takes the current `pc`/`ce`, issues single-outstanding requests to a variable-latency instruction memory, and raises a stall request to `ctrl` while a fetch is pending. It owns the IF/ID pipeline register, with stall and bubble semantics, plus a one-entry skid buffer for downstream stalls. It also latches branch redirects from ID that arrive while `pc_reg` is stalled, so no redirect is lost.

---
 rtl/inst_fetch_if.sv | 23 ++
 rtl/inst_fetch.sv | 147 ++++++++++++++
 tb/tb_inst_fetch.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction memory request/response bundle for the fetch stage
interface inst_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    // Fetch stage drives requests and consumes responses
    modport master (
        output req,
        output addr,
        input  rvalid,
        input  rdata
    );

    // Instruction memory consumes requests and returns responses
    modport slave (
        input  req,
        input  addr,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with IF/ID register, skid buffer and branch replay
module inst_fetch (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         pc_i,
    input  logic                ce_i,
    input  logic [5:0]          stall,
    input  logic                branch_flag_i,
    input  logic [31:0]         branch_target_address_i,
    inst_fetch_if.master        imem,
    output logic                stallreq_o,
    output logic                branch_flag_o,
    output logic [31:0]         branch_target_o,
    output logic [31:0]         id_pc_o,
    output logic [31:0]         id_inst_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;
    logic        pend_q;
    logic [31:0] pend_tgt;

    logic        deliver;
    logic [31:0] dlv_pc;
    logic [31:0] dlv_inst;

    // Only the PC, IF and ID stall bits matter to this stage
    logic        unused_stall;
    assign unused_stall = &{1'b0, stall[5:3]};

    // Memory request, stall request and delivery selection; stallreq_o never
    // looks at stall so no combinational loop can form through ctrl
    always_comb begin
        imem.req   = 1'b0;
        imem.addr  = addr_q;
        stallreq_o = 1'b0;
        deliver    = 1'b0;
        dlv_pc     = buf_pc;
        dlv_inst   = buf_inst;
        case (state)
            S_IDLE: begin
                imem.req   = ce_i;
                imem.addr  = pc_i;
                stallreq_o = ce_i;
            end
            S_WAIT: begin
                stallreq_o = ~imem.rvalid;
                if (imem.rvalid && !stall[1]) begin
                    deliver  = 1'b1;
                    dlv_pc   = addr_q;
                    dlv_inst = imem.rdata;
                end
            end
            S_HOLD: begin
                if (!stall[1]) begin
                    deliver = 1'b1;
                end
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

    // Fetch FSM: one outstanding request, response parked in the skid buffer
    // when IF is stalled so it is never dropped
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_IDLE;
            addr_q   <= 32'h0;
            buf_pc   <= 32'h0;
            buf_inst <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ce_i) begin
                        addr_q <= pc_i;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (stall[1]) begin
                            buf_pc   <= addr_q;
                            buf_inst <= imem.rdata;
                            state    <= S_HOLD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall[1]) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // IF/ID pipeline register: load on delivery, bubble when IF is stalled
    // but ID runs or when IF runs with nothing to hand over, else hold
    always_ff @(posedge clk) begin
        if (clr) begin
            id_pc_o   <= 32'h0;
            id_inst_o <= 32'h0;
        end else if (deliver) begin
            id_pc_o   <= dlv_pc;
            id_inst_o <= dlv_inst;
        end else if (stall[1] && !stall[2]) begin
            id_pc_o   <= 32'h0;
            id_inst_o <= 32'h0;
        end else if (!stall[1]) begin
            id_pc_o   <= 32'h0;
            id_inst_o <= 32'h0;
        end
    end

    // A redirect seen while pc_reg is frozen is kept and replayed until the
    // first cycle pc_reg can move; later redirects never overwrite it
    always_ff @(posedge clk) begin
        if (clr) begin
            pend_q   <= 1'b0;
            pend_tgt <= 32'h0;
        end else if (!stall[0]) begin
            pend_q <= 1'b0;
        end else if (branch_flag_i && !pend_q) begin
            pend_q   <= 1'b1;
            pend_tgt <= branch_target_address_i;
        end
    end

    assign branch_flag_o   = branch_flag_i | pend_q;
    assign branch_target_o = pend_q ? pend_tgt : branch_target_address_i;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        ce = 1'b0;
    logic [5:0]  stall;
    logic [5:0]  ext_stall = 6'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = 32'h0;
    logic        stallreq_o;
    logic        branch_flag_o;
    logic [31:0] branch_target_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    inst_fetch_if imem();

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 0;

    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    assign imem.rvalid = mem_rvalid;
    assign imem.rdata  = mem_rdata;

    // ctrl: IF stall request freezes PC and IF; extra downstream stalls OR in
    assign stall = ext_stall | {4'b0, stallreq_o, stallreq_o};

    inst_fetch dut (
        .clk                     (clk),
        .clr                     (clr),
        .pc_i                    (pc),
        .ce_i                    (ce),
        .stall                   (stall),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .imem                    (imem),
        .stallreq_o              (stallreq_o),
        .branch_flag_o           (branch_flag_o),
        .branch_target_o         (branch_target_o),
        .id_pc_o                 (id_pc_o),
        .id_inst_o               (id_inst_o)
    );

    // pc_reg model
    always @(posedge clk) begin
        ce <= ~clr;
        if (!ce)
            pc <= 32'h0;
        else if (!stall[0])
            pc <= branch_flag_o ? branch_target_o : pc + 32'd4;
    end

    // instruction memory model: response lat+1 cycles after the request
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_addr ^ 32'hA5A5_0000;
                mem_busy   <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
        if (imem.req) begin
            mem_addr <= imem.addr;
            if (lat == 0) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= imem.addr ^ 32'hA5A5_0000;
            end else begin
                mem_busy <= 1'b1;
                mem_cnt  <= lat - 1;
            end
        end
    end

    // long reset so any in-flight memory response drains; ends in the pc=0 request cycle
    task automatic do_reset;
        clr = 1'b1;
        repeat (6) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] e;
        clr = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++; if ({id_pc_o, id_inst_o} !== 64'h0) begin n_bad++; $display("FAIL reset_id: got %h expected 0", {id_pc_o, id_inst_o}); end
            n_cmp++; if ({imem.req, stallreq_o} !== 2'b00) begin n_bad++; $display("FAIL reset_req: got %b expected 00", {imem.req, stallreq_o}); end
        end
        clr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = 32'(i * 4);
            n_cmp++; if ({imem.req, imem.addr, stallreq_o} !== {1'b1, e, 1'b1}) begin n_bad++; $display("FAIL zw_req%0d: got %h expected %h", i, {imem.req, imem.addr, stallreq_o}, {1'b1, e, 1'b1}); end
            @(negedge clk);
            n_cmp++; if ({stallreq_o, id_pc_o, id_inst_o} !== 65'h0) begin n_bad++; $display("FAIL zw_resp%0d: got %h expected 0", i, {stallreq_o, id_pc_o, id_inst_o}); end
            @(negedge clk);
            n_cmp++; if ({id_pc_o, id_inst_o} !== {e, e ^ 32'hA5A5_0000}) begin n_bad++; $display("FAIL zw_id%0d: got %h expected %h", i, {id_pc_o, id_inst_o}, {e, e ^ 32'hA5A5_0000}); end
        end
    endtask

    task automatic test_latency;
        logic [31:0] e;
        lat = 3;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            e = 32'(f * 4);
            for (int c = 0; c < 4; c++) begin
                n_cmp++; if (stallreq_o !== 1'b1) begin n_bad++; $display("FAIL lat_stallreq f%0d c%0d: got %b expected 1", f, c, stallreq_o); end
                if (c == 0) begin
                    n_cmp++; if ({imem.req, imem.addr} !== {1'b1, e}) begin n_bad++; $display("FAIL lat_req%0d: got %h expected %h", f, {imem.req, imem.addr}, {1'b1, e}); end
                end else begin
                    n_cmp++; if ({imem.req, id_pc_o, id_inst_o} !== 65'h0) begin n_bad++; $display("FAIL lat_bubble f%0d c%0d: got %h expected 0", f, c, {imem.req, id_pc_o, id_inst_o}); end
                end
                @(negedge clk);
            end
            n_cmp++; if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL lat_release%0d: got %b expected 0", f, stallreq_o); end
            @(negedge clk);
            n_cmp++; if ({id_pc_o, id_inst_o} !== {e, e ^ 32'hA5A5_0000}) begin n_bad++; $display("FAIL lat_id%0d: got %h expected %h", f, {id_pc_o, id_inst_o}, {e, e ^ 32'hA5A5_0000}); end
        end
    endtask

    task automatic test_hold;
        lat = 0;
        do_reset();
        repeat (4) @(negedge clk);
        n_cmp++; if ({imem.req, imem.addr} !== {1'b1, 32'h8}) begin n_bad++; $display("FAIL hold_req8: got %h expected %h", {imem.req, imem.addr}, {1'b1, 32'h8}); end
        @(negedge clk);
        ext_stall = 6'b000111;
        #1;
        n_cmp++; if ({imem.rvalid, stallreq_o} !== 2'b10) begin n_bad++; $display("FAIL hold_resp: got %b expected 10", {imem.rvalid, stallreq_o}); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({imem.req, stallreq_o, id_pc_o, id_inst_o} !== 66'h0) begin n_bad++; $display("FAIL hold_keep%0d: got %h expected 0", c, {imem.req, stallreq_o, id_pc_o, id_inst_o}); end
        end
        ext_stall = 6'b0;
        @(negedge clk);
        n_cmp++; if ({id_pc_o, id_inst_o} !== {32'h8, 32'hA5A5_0008}) begin n_bad++; $display("FAIL hold_out: got %h expected %h", {id_pc_o, id_inst_o}, {32'h8, 32'hA5A5_0008}); end
        n_cmp++; if ({imem.req, imem.addr} !== {1'b1, 32'hC}) begin n_bad++; $display("FAIL hold_next_req: got %h expected %h", {imem.req, imem.addr}, {1'b1, 32'hC}); end
        repeat (2) @(negedge clk);
        n_cmp++; if ({id_pc_o, id_inst_o} !== {32'hC, 32'hA5A5_000C}) begin n_bad++; $display("FAIL hold_after: got %h expected %h", {id_pc_o, id_inst_o}, {32'hC, 32'hA5A5_000C}); end
    endtask

    task automatic test_branch;
        lat = 3;
        do_reset();
        @(negedge clk);
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h100;
        #1;
        n_cmp++; if ({branch_flag_o, branch_target_o} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL br_pass: got %h expected %h", {branch_flag_o, branch_target_o}, {1'b1, 32'h100}); end
        @(negedge clk);
        branch_flag_i = 1'b0;
        branch_target_address_i = 32'hDEAD_0000;
        #1;
        n_cmp++; if ({branch_flag_o, branch_target_o} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL br_pend: got %h expected %h", {branch_flag_o, branch_target_o}, {1'b1, 32'h100}); end
        @(negedge clk);
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h200;
        #1;
        n_cmp++; if ({branch_flag_o, branch_target_o} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL br_first_wins: got %h expected %h", {branch_flag_o, branch_target_o}, {1'b1, 32'h100}); end
        @(negedge clk);
        branch_flag_i = 1'b0;
        branch_target_address_i = 32'h0;
        #1;
        n_cmp++; if ({branch_flag_o, branch_target_o, stallreq_o} !== {1'b1, 32'h100, 1'b0}) begin n_bad++; $display("FAIL br_replay: got %h expected %h", {branch_flag_o, branch_target_o, stallreq_o}, {1'b1, 32'h100, 1'b0}); end
        @(negedge clk);
        n_cmp++; if ({imem.req, imem.addr, branch_flag_o} !== {1'b1, 32'h100, 1'b0}) begin n_bad++; $display("FAIL br_target_req: got %h expected %h", {imem.req, imem.addr, branch_flag_o}, {1'b1, 32'h100, 1'b0}); end
        n_cmp++; if ({id_pc_o, id_inst_o} !== {32'h0, 32'hA5A5_0000}) begin n_bad++; $display("FAIL br_slot_id: got %h expected %h", {id_pc_o, id_inst_o}, {32'h0, 32'hA5A5_0000}); end
    endtask

    task automatic test_reset_mid_fetch;
        lat = 1;
        do_reset();
        @(negedge clk);
        n_cmp++; if (stallreq_o !== 1'b1) begin n_bad++; $display("FAIL rmf_wait: got %b expected 1", stallreq_o); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        n_cmp++; if ({imem.rvalid, imem.req, stallreq_o} !== 3'b100) begin n_bad++; $display("FAIL rmf_late: got %b expected 100", {imem.rvalid, imem.req, stallreq_o}); end
        n_cmp++; if ({id_pc_o, id_inst_o} !== 64'h0) begin n_bad++; $display("FAIL rmf_id_clr: got %h expected 0", {id_pc_o, id_inst_o}); end
        @(negedge clk);
        n_cmp++; if ({imem.req, imem.addr, stallreq_o} !== {1'b1, 32'h0, 1'b1}) begin n_bad++; $display("FAIL rmf_req: got %h expected %h", {imem.req, imem.addr, stallreq_o}, {1'b1, 32'h0, 1'b1}); end
        n_cmp++; if ({id_pc_o, id_inst_o} !== 64'h0) begin n_bad++; $display("FAIL rmf_ignored: got %h expected 0", {id_pc_o, id_inst_o}); end
        @(negedge clk);
        n_cmp++; if (stallreq_o !== 1'b1) begin n_bad++; $display("FAIL rmf_wait2: got %b expected 1", stallreq_o); end
        repeat (2) @(negedge clk);
        n_cmp++; if ({id_pc_o, id_inst_o} !== {32'h0, 32'hA5A5_0000}) begin n_bad++; $display("FAIL rmf_id: got %h expected %h", {id_pc_o, id_inst_o}, {32'h0, 32'hA5A5_0000}); end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_latency();
        test_branch();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
